// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, sizes and ShiftRows tables for the byte-serial AES datapath
package aes_pkg;
   localparam int BYTE_W      = 8;
   localparam int BLOCK_BYTES = 16;
   localparam int SR_LATENCY  = 12;
   localparam int SR_DEPTH    = 24;
   localparam int CNT_W       = $clog2(BLOCK_BYTES);
   localparam int SEL_W       = $clog2(SR_DEPTH + 1);
   typedef logic [BYTE_W-1:0] byte_t;
   typedef logic [CNT_W-1:0]  idx_t;
   typedef logic [SEL_W-1:0]  sel_t;
   // source byte index within the block for each output byte position
   localparam idx_t K [BLOCK_BYTES] = '{
      4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
      4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11
   };
   // select table: how many edges ago output byte j's source entered the stream
   localparam sel_t D [BLOCK_BYTES] = '{
      5'd12, 5'd8, 5'd4, 5'd0, 5'd12, 5'd8, 5'd4, 5'd16,
      5'd12, 5'd8, 5'd20, 5'd16, 5'd12, 5'd24, 5'd20, 5'd16
   };
   function automatic sel_t d_of(input idx_t j);
      return sel_t'(SR_LATENCY + int'(j) - int'(K[j]));
   endfunction
endpackage

// File: rtl/shift_rows_delay_line.sv
// shift_rows_delay_line: 24-deep byte shift register with one selectable tap
module shift_rows_delay_line
   import aes_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  byte_t din,
   input  sel_t  sel,
   output byte_t tap
);
   byte_t sr_q [SR_DEPTH];
   byte_t sr_d [SR_DEPTH];
   // newest byte enters at sr[0]; tap 0 bypasses the line to return the byte arriving now
   always_comb begin
      sr_d[0] = din;
      for (int i = 1; i < SR_DEPTH; i++) sr_d[i] = sr_q[i-1];
      tap = (sel == '0) ? din : sr_q[sel - sel_t'(1)];
   end
   // shift one position per edge, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SR_DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end
endmodule

// File: rtl/shift_rows.sv
// shift_rows: byte-serial AES ShiftRows with continuous throughput and fixed 12-cycle latency
module shift_rows
   import aes_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] inBits,
   output logic [BYTE_W-1:0] outBits,
   output logic              ready
);
   idx_t  in_cnt_q, in_cnt_d, out_idx;
   byte_t out_q, out_d, tap;
   logic  ready_q, ready_d;
   sel_t  sel;
   shift_rows_delay_line u_dl (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (inBits),
      .sel   (sel),
      .tap   (tap)
   );
   // output position runs 4 ahead of the input position; ready latches when byte 0 of block 0 is due
   always_comb begin
      in_cnt_d = in_cnt_q + idx_t'(1);
      out_idx  = in_cnt_q + idx_t'(BLOCK_BYTES - SR_LATENCY);
      sel      = D[out_idx];
      out_d    = tap;
      ready_d  = ready_q | (in_cnt_q == idx_t'(SR_LATENCY));
   end
   // counter, output byte and ready registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt_q <= '0;
         out_q    <= '0;
         ready_q  <= 1'b0;
      end else begin
         in_cnt_q <= in_cnt_d;
         out_q    <= out_d;
         ready_q  <= ready_d;
      end
   end
   assign outBits = out_q;
   assign ready   = ready_q;
endmodule

// File: tb/tb_shift_rows.sv
// tb_shift_rows: scoreboard bench for the byte-serial ShiftRows stage
module tb_shift_rows;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] inBits = 8'h00;
   logic [7:0] outBits;
   logic       ready;
   int         errors = 0;
   int         checks = 0;
   int         n_edges = 0;
   logic [7:0] exp_q[$];
   logic [7:0] stim[$];

   shift_rows dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inBits  (inBits),
      .outBits (outBits),
      .ready   (ready)
   );

   always #5 clk = ~clk;

   // monitor: ready must be 0 on edges E0..E0+11 and 1 after; valid bytes pop the scoreboard
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         n_edges = 0;
      end else begin
         checks++;
         if (ready !== (n_edges >= 12)) begin
            errors++;
            $display("FAIL ready_timing edge=%0d got=%b exp=%b", n_edges, ready, (n_edges >= 12));
         end
         if (ready === 1'b1 && exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (outBits !== e) begin
               errors++;
               $display("FAIL out_byte edge=%0d got=%h exp=%h", n_edges, outBits, e);
            end
         end
         n_edges++;
      end
   end

   function automatic void push_perm(input int base);
      for (int j = 0; j < 16; j++) begin
         int r, c;
         r = j % 4;
         c = j / 4;
         exp_q.push_back(stim[base + r + 4 * ((c + r) % 4)]);
      end
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (outBits !== 8'h00 || ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_now got=%h/%b exp=00/0", outBits, ready);
      end
      exp_q.delete();
      stim.delete();
   endtask

   task automatic stream(input int n);
      @(negedge clk);
      rst_n = 1'b1;
      inBits = stim[0];
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         inBits = stim[i];
      end
   endtask

   task automatic drain();
      repeat (16) begin
         @(negedge clk);
         inBits = 8'($urandom);
      end
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (4) begin
         @(negedge clk);
         inBits = 8'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if (outBits !== 8'h00 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got=%h/%b exp=00/0", outBits, ready);
         end
      end
   endtask

   task automatic test_fips();
      logic [7:0] vin [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                               8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
      logic [7:0] vout[16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                               8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         stim.push_back(vin[i]);
         exp_q.push_back(vout[i]);
      end
      stream(16);
      drain();
   endtask

   task automatic test_index();
      do_reset();
      for (int i = 0; i < 32; i++) stim.push_back(8'(i));
      push_perm(0);
      push_perm(16);
      stream(32);
      drain();
   endtask

   task automatic test_const();
      do_reset();
      stim.push_back(8'hd4);
      stim.push_back(8'h27);
      for (int i = 2; i < 16; i++) stim.push_back(8'h55);
      for (int j = 0; j < 16; j++) exp_q.push_back(j == 0 ? 8'hd4 : j == 13 ? 8'h27 : 8'h55);
      stream(16);
      drain();
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 32; i++) stim.push_back(8'($urandom));
      push_perm(0);
      push_perm(16);
      stream(23);
      do_reset();
      for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
      push_perm(0);
      stream(16);
      drain();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1600; i++) stim.push_back(8'($urandom));
      for (int b = 0; b < 100; b++) push_perm(16 * b);
      stream(1600);
      drain();
   endtask

   initial begin
      test_reset();
      test_fips();
      test_index();
      test_const();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
